// File: rtl/ysyx_22041211_wb_pkg.sv
// Shared types for the write-back arbiter: register index width, grant owner
// and the write-request bundle.
package ysyx_22041211_wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic {
    GNT_EXU = 1'b0,
    GNT_LSU = 1'b1
  } grant_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_req_t;
endpackage

// File: rtl/ysyx_22041211_wb_arbiter_if.sv
// Issue/hazard, EXU/LSU request and register-file write signals of the
// write-back arbiter; slave is the arbiter side, master the pipeline side.
interface ysyx_22041211_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  import ysyx_22041211_wb_pkg::*;

  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic                  issue_ready;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  rs1_fwd_valid;
  logic                  rs2_fwd_valid;
  logic [DATA_WIDTH-1:0] rs1_fwd_data;
  logic [DATA_WIDTH-1:0] rs2_fwd_data;
  logic                  exu_valid;
  logic [REG_ADDR_W-1:0] exu_rd;
  logic [DATA_WIDTH-1:0] exu_data;
  logic                  exu_ready;
  logic                  lsu_valid;
  logic [REG_ADDR_W-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic                  lsu_ready;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_rd;
  logic [DATA_WIDTH-1:0] rf_wdata;

  modport slave (
    input  issue_valid, issue_rd, rs1, rs2,
    input  exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
    output issue_ready, rs1_busy, rs2_busy,
    output rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_data, rs2_fwd_data,
    output exu_ready, lsu_ready, rf_we, rf_rd, rf_wdata
  );

  modport master (
    output issue_valid, issue_rd, rs1, rs2,
    output exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
    input  issue_ready, rs1_busy, rs2_busy,
    input  rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_data, rs2_fwd_data,
    input  exu_ready, lsu_ready, rf_we, rf_rd, rf_wdata
  );
endinterface

// File: rtl/ysyx_22041211_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register (x0 never
// busy), set on dispatch, cleared by the register-file write.
module ysyx_22041211_scoreboard
  import ysyx_22041211_wb_pkg::*;
#(
  parameter int REG_NUM = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] chk_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  chk_busy,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [REG_NUM-1:0]    busy
);
  logic [REG_NUM-1:1] busy_q;
  logic [REG_NUM-1:0] set_mask;
  logic [REG_NUM-1:0] clr_mask;
  logic [REG_NUM-1:0] busy_nxt;

  assign busy = {busy_q, 1'b0};

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_rd] = 1'b1;
    if (clr_en) clr_mask[clr_rd] = 1'b1;
    busy_nxt = (busy & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_nxt[REG_NUM-1:1];
  end

  assign chk_busy = busy[chk_rd];
  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];
endmodule

// File: rtl/ysyx_22041211_wb_arbiter.sv
// Round-robin write-back arbiter (EXU vs LSU) with registered register-file
// write port and hazard scoreboard. Optional bypass: YSYX_22041211_WB_BYPASS_EN.
module ysyx_22041211_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32
) (
  input logic                        clk,
  input logic                        rst,
  ysyx_22041211_wb_arbiter_if.slave  bus
);
  import ysyx_22041211_wb_pkg::*;

  grant_e                last_grant;
  wb_req_t               exu_req;
  wb_req_t               lsu_req;
  wb_req_t               win_req;
  logic                  exu_gnt;
  logic                  lsu_gnt;
  logic                  rf_we_q;
  logic [REG_ADDR_W-1:0] rf_rd_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic                  issue_busy;
  logic                  issue_ready;
  logic                  sb_rs1_busy;
  logic                  sb_rs2_busy;
  logic [REG_NUM-1:0]    busy_vec;

  assign exu_req = '{valid: bus.exu_valid, rd: bus.exu_rd, data: bus.exu_data};
  assign lsu_req = '{valid: bus.lsu_valid, rd: bus.lsu_rd, data: bus.lsu_data};

  // On contention the side that did not win last time gets the port.
  always_comb begin
    exu_gnt = bus.exu_valid && (!bus.lsu_valid || last_grant == GNT_LSU);
    lsu_gnt = bus.lsu_valid && !exu_gnt;
    win_req = exu_gnt ? exu_req : lsu_req;
  end

  assign bus.exu_ready = exu_gnt;
  assign bus.lsu_ready = lsu_gnt;

  // A write to x0 is consumed but never reaches the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= GNT_LSU;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= (exu_gnt || lsu_gnt) && (win_req.rd != '0);
      if (exu_gnt || lsu_gnt) begin
        last_grant <= exu_gnt ? GNT_EXU : GNT_LSU;
        rf_rd_q    <= win_req.rd;
        rf_wdata_q <= win_req.data;
      end
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_rd    = rf_rd_q;
  assign bus.rf_wdata = rf_wdata_q;

  assign issue_ready     = !bus.issue_valid || !issue_busy;
  assign bus.issue_ready = issue_ready;

  ysyx_22041211_scoreboard #(.REG_NUM(REG_NUM)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (bus.issue_valid && issue_ready && bus.issue_rd != '0),
    .set_rd   (bus.issue_rd),
    .clr_en   (rf_we_q),
    .clr_rd   (rf_rd_q),
    .chk_rd   (bus.issue_rd),
    .rs1      (bus.rs1),
    .rs2      (bus.rs2),
    .chk_busy (issue_busy),
    .rs1_busy (sb_rs1_busy),
    .rs2_busy (sb_rs2_busy),
    .busy     (busy_vec)
  );

`ifdef YSYX_22041211_WB_BYPASS_EN
  logic rs1_hit;
  logic rs2_hit;
  assign rs1_hit           = rf_we_q && rf_rd_q == bus.rs1 && bus.rs1 != '0;
  assign rs2_hit           = rf_we_q && rf_rd_q == bus.rs2 && bus.rs2 != '0;
  assign bus.rs1_fwd_valid = rs1_hit;
  assign bus.rs2_fwd_valid = rs2_hit;
  assign bus.rs1_fwd_data  = rs1_hit ? rf_wdata_q : '0;
  assign bus.rs2_fwd_data  = rs2_hit ? rf_wdata_q : '0;
  assign bus.rs1_busy      = sb_rs1_busy && !rs1_hit;
  assign bus.rs2_busy      = sb_rs2_busy && !rs2_hit;
`else
  assign bus.rs1_fwd_valid = 1'b0;
  assign bus.rs2_fwd_valid = 1'b0;
  assign bus.rs1_fwd_data  = '0;
  assign bus.rs2_fwd_data  = '0;
  assign bus.rs1_busy      = sb_rs1_busy;
  assign bus.rs2_busy      = sb_rs2_busy;
`endif
endmodule

// File: tb/tb_ysyx_22041211_wb_arbiter.sv
// Directed bench for the write-back arbiter: scoreboard stalls, round-robin
// order, x0 writes, bypass (YSYX_22041211_WB_BYPASS_EN) and mid-write reset.
module tb_ysyx_22041211_wb_arbiter;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  ysyx_22041211_wb_arbiter_if bus ();

  ysyx_22041211_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every register-file write must retire a pending scoreboard entry.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.rf_we === 1'b1) begin
      n_assert++;
      assert (dut.busy_vec[bus.rf_rd] === 1'b1) else begin
        n_fail++;
        $error("FAIL wb_without_busy observed=0 expected=1 rd=%0d", bus.rf_rd);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

`ifdef YSYX_22041211_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
    bus.exu_valid = 1'b0; bus.exu_rd = '0; bus.exu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    repeat (2) settle();
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_rf_rd", 32'(bus.rf_rd), 32'd0);
    chk("rst_rf_wdata", bus.rf_wdata, 32'd0);
    chk("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
    chk("rst_exu_ready", 32'(bus.exu_ready), 32'd0);
    chk("rst_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    rst = 1'b1;

    // Dispatch rd=5, then WAW stall on a second rd=5.
    step(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; bus.rs1 = 5'd5;
    settle();
    chk("issue5_ready", 32'(bus.issue_ready), 32'd1);
    chk("issue5_rs1_busy_pre", 32'(bus.rs1_busy), 32'd0);
    step(); settle();
    chk("issue5_rs1_busy", 32'(bus.rs1_busy), 32'd1);
    chk("issue5_waw_stall", 32'(bus.issue_ready), 32'd0);

    // EXU writes rd=5.
    step(); bus.issue_valid = 1'b0;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd5; bus.exu_data = 32'h1234;
    settle();
    chk("exu5_exu_ready", 32'(bus.exu_ready), 32'd1);
    chk("exu5_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    chk("exu5_rf_we_pre", 32'(bus.rf_we), 32'd0);
    step(); bus.exu_valid = 1'b0; bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
    settle();
    chk("exu5_rf_we", 32'(bus.rf_we), 32'd1);
    chk("exu5_rf_rd", 32'(bus.rf_rd), 32'd5);
    chk("exu5_rf_wdata", bus.rf_wdata, 32'h1234);
    chk("exu5_issue_still_stalled", 32'(bus.issue_ready), 32'd0);
    chk("exu5_rs1_busy", 32'(bus.rs1_busy), BYP ? 32'd0 : 32'd1);
    chk("exu5_rs1_fwd_valid", 32'(bus.rs1_fwd_valid), BYP ? 32'd1 : 32'd0);
    chk("exu5_rs1_fwd_data", bus.rs1_fwd_data, BYP ? 32'h1234 : 32'd0);
    step(); settle();
    chk("exu5_rf_we_post", 32'(bus.rf_we), 32'd0);
    chk("exu5_rs1_cleared", 32'(bus.rs1_busy), 32'd0);
    chk("reissue5_ready", 32'(bus.issue_ready), 32'd1);
    step(); bus.issue_valid = 1'b0;
    settle();
    chk("reissue5_rs1_busy", 32'(bus.rs1_busy), 32'd1);

    // LSU write to x0: granted, consumed, never written.
    step(); bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hFFFF;
    bus.rs1 = 5'd0;
    settle();
    chk("x0_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    chk("x0_exu_ready", 32'(bus.exu_ready), 32'd0);
    chk("x0_rs1_busy", 32'(bus.rs1_busy), 32'd0);
    step(); bus.lsu_valid = 1'b0;
    settle();
    chk("x0_rf_we", 32'(bus.rf_we), 32'd0);
    chk("x0_rs1_busy_wb", 32'(bus.rs1_busy), 32'd0);
    chk("x0_rs1_fwd_valid", 32'(bus.rs1_fwd_valid), 32'd0);

    // Contention: dispatch rd 1..4, then both requesters valid.
    for (int r = 1; r <= 4; r++) begin
      step(); bus.issue_valid = 1'b1; bus.issue_rd = 5'(r);
      settle();
      chk("rr_issue_ready", 32'(bus.issue_ready), 32'd1);
    end
    step(); bus.issue_valid = 1'b0;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd1; bus.exu_data = 32'hA1;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'hB3;
    bus.rs1 = 5'd4; bus.rs2 = 5'd1;
    settle();
    chk("rr0_exu_ready", 32'(bus.exu_ready), 32'd1);
    chk("rr0_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    chk("rr0_rs2_busy", 32'(bus.rs2_busy), 32'd1);
    step(); bus.exu_rd = 5'd2; bus.exu_data = 32'hA2;
    settle();
    chk("rr1_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    chk("rr1_exu_ready", 32'(bus.exu_ready), 32'd0);
    chk("rr1_rf_rd", 32'(bus.rf_rd), 32'd1);
    chk("rr1_rf_wdata", bus.rf_wdata, 32'hA1);
    chk("rr1_rs2_busy", 32'(bus.rs2_busy), BYP ? 32'd0 : 32'd1);
    step(); bus.lsu_rd = 5'd4; bus.lsu_data = 32'hB4;
    settle();
    chk("rr2_exu_ready", 32'(bus.exu_ready), 32'd1);
    chk("rr2_rf_rd", 32'(bus.rf_rd), 32'd3);
    step(); bus.exu_valid = 1'b0;
    settle();
    chk("rr3_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    chk("rr3_rf_rd", 32'(bus.rf_rd), 32'd2);
    step(); bus.lsu_valid = 1'b0;
    settle();
    chk("rr4_rf_we", 32'(bus.rf_we), 32'd1);
    chk("rr4_rf_rd", 32'(bus.rf_rd), 32'd4);
    chk("rr4_rf_wdata", bus.rf_wdata, 32'hB4);
    chk("rr4_rs1_fwd_data", bus.rs1_fwd_data, BYP ? 32'hB4 : 32'd0);

    // Reset while a write to rd=7 sits in the write stage.
    step(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.rs1 = 5'd5; bus.rs2 = 5'd7;
    step(); bus.issue_valid = 1'b0;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd7; bus.exu_data = 32'h77;
    settle();
    chk("rst7_exu_ready", 32'(bus.exu_ready), 32'd1);
    chk("rst7_rs2_busy", 32'(bus.rs2_busy), 32'd1);
    step(); bus.exu_valid = 1'b0;
    settle();
    chk("rst7_rf_we_pre", 32'(bus.rf_we), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst7_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst7_rf_rd", 32'(bus.rf_rd), 32'd0);
    chk("rst7_rf_wdata", bus.rf_wdata, 32'd0);
    chk("rst7_rs1_busy", 32'(bus.rs1_busy), 32'd0);
    chk("rst7_rs2_busy", 32'(bus.rs2_busy), 32'd0);
    step(); settle();
    chk("rst7_hold_rf_we", 32'(bus.rf_we), 32'd0);
    rst = 1'b1;

    // After release the first contention goes to EXU.
    step(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd8;
    step(); bus.issue_rd = 5'd9;
    step(); bus.issue_valid = 1'b0;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd8; bus.exu_data = 32'h88;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h99;
    settle();
    chk("post_rst_exu_ready", 32'(bus.exu_ready), 32'd1);
    chk("post_rst_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    step(); bus.exu_valid = 1'b0;
    settle();
    chk("post_rst_rf_rd8", 32'(bus.rf_rd), 32'd8);
    chk("post_rst_lsu_ready2", 32'(bus.lsu_ready), 32'd1);
    step(); bus.lsu_valid = 1'b0;
    settle();
    chk("post_rst_rf_rd9", 32'(bus.rf_rd), 32'd9);
    chk("post_rst_rf_wdata9", bus.rf_wdata, 32'h99);
    step(); settle();
    chk("post_rst_idle_rf_we", 32'(bus.rf_we), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
